// File: rtl/dac_sample_sequencer.sv
// ---------------------------------------------------------------------------
// dac_sample_sequencer
//
// Purpose:
//   Sample-rate scheduler and mixer that feeds the PDM DAC. A free-running
//   divider produces one tick every DIV clocks. Each tick starts a frame.
//   The frame reads the voices one per cycle through a single shared adder,
//   applies the master volume, saturates, and converts the signed mix to
//   offset-binary. The resulting code is held on dac_din until the next
//   frame's OUTPUT cycle.
//
// Parameters:
//   VOICES      number of voice inputs (>= 2)
//   SAMPLE_BITS width of each signed voice sample
//   DATA_BITS   width of the unsigned DAC code
//   DIV         clocks per sample period (>= VOICES+3)
//
// Ports:
//   clk           in   single clock
//   rst_n         in   asynchronous active-low reset
//   voice_data    in   packed signed samples, voice i at [i*SAMPLE_BITS +: SAMPLE_BITS]
//   voice_en      in   per-voice enable, disabled voice contributes 0
//   volume        in   unsigned master gain, 256 = unity
//   mute          in   forces midscale at the next update
//   dac_din       out  DAC code (offset binary)
//   sample_strobe out  one-cycle pulse in the cycle dac_din takes a new value
//   voice_sel     out  index of the voice being read this cycle
//   busy          out  high while a frame is being computed
// ---------------------------------------------------------------------------
module dac_sample_sequencer #(
    parameter int VOICES      = 4,
    parameter int SAMPLE_BITS = 12,
    parameter int DATA_BITS   = 12,
    parameter int DIV         = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [VOICES*SAMPLE_BITS-1:0]   voice_data,
    input  logic [VOICES-1:0]               voice_en,
    input  logic [8:0]                      volume,
    input  logic                            mute,
    output logic [DATA_BITS-1:0]            dac_din,
    output logic                            sample_strobe,
    output logic [$clog2(VOICES)-1:0]       voice_sel,
    output logic                            busy
);

    localparam int VSEL_W = $clog2(VOICES);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    // The accumulator grows by clog2(VOICES) bits so the sum of all voices fits.
    localparam int ACC_W  = SAMPLE_BITS + VSEL_W;
    // Accumulator times the 10-bit zero-extended volume.
    localparam int PROD_W = ACC_W + 10;
    // Comparison width large enough to hold both the scaled value and the limits.
    localparam int CMP_W  = PROD_W + DATA_BITS;

    localparam logic signed [CMP_W-1:0] C_MAX = CMP_W'((64'sd1 <<< (DATA_BITS - 1)) - 64'sd1);
    localparam logic signed [CMP_W-1:0] C_MIN = -C_MAX - CMP_W'(1);
    localparam logic [DATA_BITS-1:0]    MIDSCALE = {1'b1, {(DATA_BITS-1){1'b0}}};

    // Parameter sanity: a frame must fit inside one sample period.
    if (VOICES < 2 || DIV < VOICES + 3) begin : g_paramCheck
        $error("dac_sample_sequencer: need VOICES >= 2 and DIV >= VOICES+3");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SCALE,
        S_OUTPUT
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;
    logic [DIV_W-1:0]          r_divCnt;
    logic                      w_tick;
    logic [VSEL_W-1:0]         r_voiceSel;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [PROD_W-1:0]  r_scaled;
    logic [DATA_BITS-1:0]      r_dacDin;
    logic                      r_strobe;
    logic                      r_busy;

    logic [SAMPLE_BITS-1:0]    w_sample;
    logic signed [ACC_W-1:0]   w_sampleExt;
    logic                      w_voiceEn;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [PROD_W-1:0]  w_shifted;
    logic signed [CMP_W-1:0]   w_scaledExt;
    logic [DATA_BITS-1:0]      w_clamped;
    logic [DATA_BITS-1:0]      w_code;

    // Free-running sample-rate divider; tick marks the last count of a period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_divCnt <= '0;
        end else if (r_divCnt == DIV_W'(DIV - 1)) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
        end
    end

    assign w_tick = (r_divCnt == DIV_W'(DIV - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: one ACCUM cycle per voice, then SCALE and OUTPUT.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_nextState = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (r_voiceSel == VSEL_W'(VOICES - 1)) begin
                    w_nextState = S_SCALE;
                end
            end
            S_SCALE: begin
                w_nextState = S_OUTPUT;
            end
            S_OUTPUT: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Voice read mux driven by the current slot index.
    always_comb begin
        w_sample = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (r_voiceSel == VSEL_W'(i)) begin
                w_sample = voice_data[i*SAMPLE_BITS +: SAMPLE_BITS];
            end
        end
    end

    assign w_voiceEn   = voice_en[r_voiceSel];
    assign w_sampleExt = {{(ACC_W-SAMPLE_BITS){w_sample[SAMPLE_BITS-1]}}, w_sample};

    // Signed multiply by the zero-extended gain, then an arithmetic shift so
    // that negative results round toward negative infinity.
    assign w_prod    = r_acc * $signed({1'b0, volume});
    assign w_shifted = w_prod >>> 8;

    // Saturate to the signed DATA_BITS range and flip the MSB for offset binary.
    assign w_scaledExt = {{(CMP_W-PROD_W){r_scaled[PROD_W-1]}}, r_scaled};

    always_comb begin
        w_clamped = w_scaledExt[DATA_BITS-1:0];
        if (w_scaledExt > C_MAX) begin
            w_clamped = {1'b0, {(DATA_BITS-1){1'b1}}};
        end else if (w_scaledExt < C_MIN) begin
            w_clamped = {1'b1, {(DATA_BITS-1){1'b0}}};
        end
    end

    assign w_code = {~w_clamped[DATA_BITS-1], w_clamped[DATA_BITS-2:0]};

    // Datapath: slot counter, shared accumulator, scaled result and the held
    // DAC code. Each register only moves in the state that owns it, so an
    // aborted frame can never leak a partial value to dac_din.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_voiceSel <= '0;
            r_acc      <= '0;
            r_scaled   <= '0;
            r_dacDin   <= MIDSCALE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_acc      <= '0;
                        r_voiceSel <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_voiceEn) begin
                        r_acc <= r_acc + w_sampleExt;
                    end
                    if (r_voiceSel == VSEL_W'(VOICES - 1)) begin
                        r_voiceSel <= '0;
                    end else begin
                        r_voiceSel <= r_voiceSel + VSEL_W'(1);
                    end
                end
                S_SCALE: begin
                    r_scaled <= w_shifted;
                end
                S_OUTPUT: begin
                    r_dacDin <= mute ? MIDSCALE : w_code;
                end
                default: begin
                    r_voiceSel <= '0;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with
    // the cycle the FSM actually occupies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_strobe <= (w_nextState == S_OUTPUT);
            r_busy   <= (w_nextState != S_IDLE);
        end
    end

    assign dac_din       = r_dacDin;
    assign sample_strobe = r_strobe;
    assign voice_sel     = r_voiceSel;
    assign busy          = r_busy;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dac_sample_sequencer
//
// Directed bench for dac_sample_sequencer with VOICES=4, SAMPLE_BITS=12,
// DATA_BITS=12, DIV=16. Each scenario task drives its own stimulus and checks
// hand-computed expected codes. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_dac_sample_sequencer;

    localparam int VOICES      = 4;
    localparam int SAMPLE_BITS = 12;
    localparam int DATA_BITS   = 12;
    localparam int DIV         = 16;
    localparam int BUDGET      = 60;

    logic                          clk;
    logic                          rst_n;
    logic [VOICES*SAMPLE_BITS-1:0] voice_data;
    logic [VOICES-1:0]             voice_en;
    logic [8:0]                    volume;
    logic                          mute;
    logic [DATA_BITS-1:0]          dac_din;
    logic                          sample_strobe;
    logic [1:0]                    voice_sel;
    logic                          busy;

    int total;
    int bad;

    dac_sample_sequencer #(
        .VOICES      (VOICES),
        .SAMPLE_BITS (SAMPLE_BITS),
        .DATA_BITS   (DATA_BITS),
        .DIV         (DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .voice_data    (voice_data),
        .voice_en      (voice_en),
        .volume        (volume),
        .mute          (mute),
        .dac_din       (dac_din),
        .sample_strobe (sample_strobe),
        .voice_sel     (voice_sel),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setVoices(input int v0, input int v1, input int v2, input int v3);
        voice_data = {12'(v3), 12'(v2), 12'(v1), 12'(v0)};
    endtask

    // Wait for the next strobe, then one more edge so the new code is visible.
    task automatic runFrame(output logic [DATA_BITS-1:0] code, output bit ok);
        ok   = 1'b0;
        code = '0;
        for (int i = 0; i < BUDGET; i++) begin
            step();
            if (sample_strobe === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        code = dac_din;
    endtask

    // Wait until busy rises: the bench is then in the first ACCUM slot.
    task automatic waitBusy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            step();
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        setVoices(100, 200, -50, 0);
        voice_en = 4'b1111;
        volume   = 9'd256;
        mute     = 1'b0;
        repeat (3) step();
        total++;
        if (dac_din !== 12'd2048) begin
            bad++;
            $display("[TB] FAIL reset_dac_din: got %0d want 2048", dac_din);
        end
        total++;
        if (sample_strobe !== 1'b0 || busy !== 1'b0 || voice_sel !== 2'd0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got strobe=%b busy=%b sel=%0d want 0 0 0",
                     sample_strobe, busy, voice_sel);
        end
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            step();
            if (sample_strobe === 1'b1) begin
                n = i;
                break;
            end
            if (dac_din !== 12'd2048) begin
                n = -i;
                break;
            end
        end
        total++;
        if (n != 21) begin
            bad++;
            $display("[TB] FAIL reset_first_strobe: got cycle %0d want 21", n);
        end
        step();
        total++;
        if (dac_din !== 12'd2298) begin
            bad++;
            $display("[TB] FAIL reset_first_code: got %0d want 2298", dac_din);
        end
    endtask

    task automatic test_basic_mix();
        bit ok;
        waitBusy(ok);
        total++;
        if (!ok || voice_sel !== 2'd0 || sample_strobe !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mix_slot0: got ok=%b sel=%0d strobe=%b want 1 0 0",
                     ok, voice_sel, sample_strobe);
        end
        for (int k = 1; k < 4; k++) begin
            step();
            total++;
            if (voice_sel !== 2'(k) || busy !== 1'b1 || sample_strobe !== 1'b0) begin
                bad++;
                $display("[TB] FAIL mix_slot%0d: got sel=%0d busy=%b strobe=%b want %0d 1 0",
                         k, voice_sel, busy, sample_strobe, k);
            end
        end
        step();
        total++;
        if (busy !== 1'b1 || sample_strobe !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mix_scale: got busy=%b strobe=%b want 1 0", busy, sample_strobe);
        end
        step();
        total++;
        if (busy !== 1'b1 || sample_strobe !== 1'b1 || dac_din !== 12'd2298) begin
            bad++;
            $display("[TB] FAIL mix_output: got busy=%b strobe=%b din=%0d want 1 1 2298",
                     busy, sample_strobe, dac_din);
        end
        step();
        total++;
        if (dac_din !== 12'd2298 || busy !== 1'b0 || sample_strobe !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mix_result: got din=%0d busy=%b strobe=%b want 2298 0 0",
                     dac_din, busy, sample_strobe);
        end
    endtask

    task automatic test_saturation();
        logic [DATA_BITS-1:0] code;
        bit ok;
        setVoices(2047, 2047, 2047, 2047);
        volume = 9'd256;
        runFrame(code, ok);
        total++;
        if (!ok || code !== 12'd4095) begin
            bad++;
            $display("[TB] FAIL sat_pos: got %0d (ok=%b) want 4095", code, ok);
        end
        setVoices(-2048, -2048, -2048, -2048);
        runFrame(code, ok);
        total++;
        if (!ok || code !== 12'd0) begin
            bad++;
            $display("[TB] FAIL sat_neg: got %0d (ok=%b) want 0", code, ok);
        end
        setVoices(1000, 0, 0, 0);
        volume = 9'd511;
        runFrame(code, ok);
        total++;
        if (!ok || code !== 12'd4044) begin
            bad++;
            $display("[TB] FAIL vol_max: got %0d (ok=%b) want 4044", code, ok);
        end
    endtask

    task automatic test_volume();
        logic [DATA_BITS-1:0] code;
        bit ok;
        setVoices(400, 300, 200, 100);
        volume = 9'd128;
        runFrame(code, ok);
        total++;
        if (!ok || code !== 12'd2548) begin
            bad++;
            $display("[TB] FAIL vol_half: got %0d (ok=%b) want 2548", code, ok);
        end
        setVoices(-3, 0, 0, 0);
        runFrame(code, ok);
        total++;
        if (!ok || code !== 12'd2046) begin
            bad++;
            $display("[TB] FAIL vol_round_neg: got %0d (ok=%b) want 2046", code, ok);
        end
        setVoices(1000, 0, 0, 0);
        volume = 9'd0;
        runFrame(code, ok);
        total++;
        if (!ok || code !== 12'd2048) begin
            bad++;
            $display("[TB] FAIL vol_zero: got %0d (ok=%b) want 2048", code, ok);
        end
    endtask

    task automatic test_masking();
        logic [DATA_BITS-1:0] code;
        bit ok;
        setVoices(10, 20, 40, 80);
        voice_en = 4'b0101;
        volume   = 9'd256;
        runFrame(code, ok);
        total++;
        if (!ok || code !== 12'd2098) begin
            bad++;
            $display("[TB] FAIL mask: got %0d (ok=%b) want 2098", code, ok);
        end
        // Voice 0 changes during slot 2; its slot is long past.
        waitBusy(ok);
        step();
        step();
        setVoices(999, 20, 40, 80);
        runFrame(code, ok);
        total++;
        if (!ok || code !== 12'd2098) begin
            bad++;
            $display("[TB] FAIL slot_sampling: got %0d (ok=%b) want 2098", code, ok);
        end
        setVoices(10, 20, 40, 80);
    endtask

    task automatic test_mute();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            step();
            if (sample_strobe === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        mute = 1'b1;
        step();
        total++;
        if (!ok || dac_din !== 12'd2048) begin
            bad++;
            $display("[TB] FAIL mute: got %0d (ok=%b) want 2048", dac_din, ok);
        end
        mute = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [DATA_BITS-1:0] code;
        bit ok;
        int n;
        setVoices(100, 200, -50, 0);
        voice_en = 4'b1111;
        volume   = 9'd256;
        runFrame(code, ok);
        total++;
        if (!ok || code !== 12'd2298) begin
            bad++;
            $display("[TB] FAIL pre_reset_frame: got %0d (ok=%b) want 2298", code, ok);
        end
        waitBusy(ok);
        step();
        step();
        rst_n = 1'b0;
        #1;
        total++;
        if (!ok || dac_din !== 12'd2048 || busy !== 1'b0 || sample_strobe !== 1'b0 || voice_sel !== 2'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset_outputs: got din=%0d busy=%b strobe=%b sel=%0d want 2048 0 0 0",
                     dac_din, busy, sample_strobe, voice_sel);
        end
        repeat (2) step();
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            step();
            if (sample_strobe === 1'b1) begin
                n = i;
                break;
            end
            if (dac_din !== 12'd2048) begin
                n = -i;
                break;
            end
        end
        total++;
        if (n != 21) begin
            bad++;
            $display("[TB] FAIL mid_reset_resume: got cycle %0d want 21", n);
        end
        step();
        total++;
        if (dac_din !== 12'd2298) begin
            bad++;
            $display("[TB] FAIL mid_reset_next_code: got %0d want 2298", dac_din);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        voice_data = '0;
        voice_en   = '0;
        volume     = '0;
        mute       = 1'b0;
        test_reset();
        test_basic_mix();
        test_saturation();
        test_volume();
        test_masking();
        test_mute();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
